// File: rtl/rsa_modexp_if.sv
// Request/result bundle for rsa_modexp: operands and start in, result and status out.
interface rsa_modexp_if #(
  parameter int WIDTH = 4
);
  logic             ena;
  logic             start;
  logic [WIDTH-1:0] M_i;
  logic [WIDTH-1:0] E_i;
  logic [WIDTH-1:0] N_i;
  logic [WIDTH-1:0] R_o;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output ena, start, M_i, E_i, N_i,
    input  R_o, done, busy, err
  );

  modport slave (
    input  ena, start, M_i, E_i, N_i,
    output R_o, done, busy, err
  );
endinterface

// File: rtl/rsa_modexp.sv
// rsa_modexp: R = M^E mod N, left-to-right square-and-multiply over a bit-serial modmul.
// Optional macro RSA_MODEXP_SKIPZ_EN: leading zero exponent bits cost one cycle, no square.
module rsa_modexp #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rstb,
  rsa_modexp_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, REDUCE, SQR, MUL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] m_reg, e_reg, n_reg, mr, acc, p, r_q;
  logic [CW-1:0]    step, k;
  logic             done_q, busy_q, err_q;
  logic             accept, bad_n, mm_last, finish, skip, k_dec;
  logic             step_last, k_last;
  logic [WIDTH-1:0] op_a, op_b, p_next;
  logic [WIDTH:0]   dbl, sum;
  logic [WIDTH-1:0] dbl_r, sum_r;

  assign step_last = (step == '0);
  assign k_last    = (k == '0);

  assign bus.R_o  = r_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

  // One modmul step: double then conditionally add, each folded back below N by a single subtract.
  always_comb begin
    dbl    = {p, 1'b0};
    dbl_r  = (dbl >= {1'b0, n_reg}) ? WIDTH'(dbl - {1'b0, n_reg}) : WIDTH'(dbl);
    sum    = {1'b0, dbl_r} + {1'b0, op_a};
    sum_r  = (sum >= {1'b0, n_reg}) ? WIDTH'(sum - {1'b0, n_reg}) : WIDTH'(sum);
    p_next = op_b[step] ? sum_r : dbl_r;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else if (bus.ena) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bad_n      = 1'b0;
    mm_last    = 1'b0;
    finish     = 1'b0;
    skip       = 1'b0;
    k_dec      = 1'b0;
    op_a       = '0;
    op_b       = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.N_i < WIDTH'(2)) bad_n = 1'b1;
          else                     state_next = REDUCE;
        end
      end
      REDUCE: begin
        op_a = WIDTH'(1);
        op_b = m_reg;
        if (step_last) begin
          mm_last    = 1'b1;
          state_next = SQR;
        end
      end
      SQR: begin
`ifdef RSA_MODEXP_SKIPZ_EN
        // acc is still 1 here, so squaring would not change it.
        skip = ((e_reg >> k) == '0);
`endif
        if (skip) begin
          if (k_last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            k_dec = 1'b1;
          end
        end else begin
          op_a = acc;
          op_b = acc;
          if (step_last) begin
            mm_last = 1'b1;
            if (e_reg[k]) begin
              state_next = MUL;
            end else if (k_last) begin
              finish     = 1'b1;
              state_next = IDLE;
            end else begin
              k_dec = 1'b1;
            end
          end
        end
      end
      MUL: begin
        op_a = acc;
        op_b = mr;
        if (step_last) begin
          mm_last = 1'b1;
          if (k_last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            k_dec      = 1'b1;
            state_next = SQR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      m_reg  <= '0;
      e_reg  <= '0;
      n_reg  <= '0;
      mr     <= '0;
      acc    <= '0;
      p      <= '0;
      r_q    <= '0;
      step   <= '0;
      k      <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.ena) begin
      done_q <= 1'b0;
      if (accept) begin
        m_reg <= bus.M_i;
        e_reg <= bus.E_i;
        n_reg <= bus.N_i;
        if (bad_n) begin
          r_q    <= '0;
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          err_q  <= 1'b0;
          busy_q <= 1'b1;
          acc    <= WIDTH'(1);
          p      <= '0;
          step   <= CW'(WIDTH - 1);
          k      <= CW'(WIDTH - 1);
        end
      end
      if ((state != IDLE) && !skip) begin
        p    <= mm_last ? '0 : p_next;
        step <= mm_last ? CW'(WIDTH - 1) : step - CW'(1);
      end
      if (mm_last) begin
        if (state == REDUCE) mr  <= p_next;
        else                 acc <= p_next;
      end
      if (k_dec) k <= k - CW'(1);
      if (finish) begin
        r_q    <= skip ? acc : p_next;
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Modular-exponentiation engine computing R = M^E mod N for the RSA datapath. It sits directly upstream of the ciphertext capture register: `R_o` drives that register's data input and `done` drives its load strobe. The engine uses bit-serial interleaved modular multiplication with a left-to-right square-and-multiply exponent scan.

## Interface
Parameters:
- WIDTH, 4, bit width of M, E, N and R.

Ports:
- clk  input  1  clock; all logic on posedge.
- rstb  input  1  reset, synchronous, active-low.
- ena  input  1  clock enable; when 0 all state, including outputs, holds.
- start  input  1  request; sampled only in IDLE with ena=1.
- M_i  input  WIDTH  message/base; any value, including values ≥ N.
- E_i  input  WIDTH  exponent.
- N_i  input  WIDTH  modulus; must be ≥ 2.
- R_o  output  WIDTH  result; held until the next `done`.
- done  output  1  one-cycle pulse; `R_o` and `err` are valid in the same cycle.
- busy  output  1  high while a computation is in progress.
- err  output  1  high when N < 2; updated together with `done`.

## Operation
- Reset (rstb=0 at posedge) overrides `ena` and everything else.
  - Outputs: R_o=0, done=0, busy=0, err=0.
  - State goes to IDLE.
  - Reset during a computation aborts it; no `done` is produced.
- States: IDLE, REDUCE, SQR, MUL.
- IDLE, on start=1: capture M, E, N into internal registers. Later input changes are ignored until the next `done`.
  - If N<2: R_o←0, err←1, done←1, stay in IDLE.
  - Otherwise: err←0, busy←1, acc←1, go to REDUCE.
- Modular multiply modmul(a,b):
  - Start with P=0.
  - For each bit of b, MSB first, one cycle per bit: P ← 2P mod N, then P ← (P + a) mod N if the bit is 1.
  - Each step uses one conditional subtraction of N, performed on WIDTH+1-bit intermediates.
  - All values stay < N.
- REDUCE: Mr = modmul(1, M), which equals M mod N. Takes WIDTH cycles.
- Exponent scan, bit k from WIDTH-1 down to 0:
  - SQR: acc ← modmul(acc, acc).
  - If E[k]=1: MUL: acc ← modmul(acc, Mr).
- After the last bit is processed:
  - R_o←acc, done←1 (one cycle), busy←0, return to IDLE.
- `start` while busy is ignored (it is not queued).
- E=0 yields R=1. M≡0 (mod N) yields R=0 when E≠0.

## Timing
- Let t be the posedge at which `start` is accepted, counting only ena=1 cycles.
- Default build: K = WIDTH·(1 + WIDTH + popcount(E)).
  - The final update lands at edge t+K.
  - `done`=1 and valid `R_o` appear in the cycle after edge t+K.
  - `busy` is high from after edge t through edge t+K.
- Error path: `done` and `err` are high in the cycle after edge t; `busy` never rises.
- `done` is never high for more than one consecutive enabled cycle.
- Back-to-back: `start` may be accepted in the cycle `done` is high. The new result appears K cycles later.
- ena=0 stretches every timing figure by the number of disabled cycles. A `done` pulse present when ena falls stays high until the next enabled edge.

## Configuration
- Macro: `RSA_MODEXP_SKIPZ_EN`.
- Defined: leading zero exponent bits (those above the highest set bit of E) skip SQR and cost 1 cycle each.
  - K = WIDTH + lz + WIDTH·(WIDTH − lz) + WIDTH·popcount(E), where lz is the number of leading zeros (lz = WIDTH when E=0).
- Undefined: every exponent bit costs a full SQR. No skip logic is synthesized.
- Results are identical in both builds.

## Test plan
All scenarios use WIDTH=4.
- M=7, E=3, N=11, start pulse → R_o=2, err=0.
  - done at t+29, i.e. K=28.
  - With `RSA_MODEXP_SKIPZ_EN`: K=22.
- M=13, E=2, N=11 (M ≥ N) → R_o=4, K=24.
- M=9, E=0, N=5 → R_o=1, K=20 (K=8 with `RSA_MODEXP_SKIPZ_EN`).
- N=1 (and separately N=0), any M and E → done and err high the cycle after t, R_o=0, busy stays 0.
- Reset mid-operation:
  - Start M=7, E=3, N=11; assert rstb=0 at t+10 → next cycle R_o=0, busy=0, done=0.
  - No `done` follows.
  - A new start then gives a normal result.
- Stress the other inputs during a run (M=7, E=3, N=11):
  - Toggle ena=0 for 5 cycles mid-run → R_o=2, done at t+34.
  - Pulse start at t+3 → ignored, single `done`.
  - Change M_i/E_i/N_i at t+1 → result unaffected.
